// File: rtl/csoc_tester_pkg.sv
// Shared types and constants for the CSoC test harness: UART state encodings,
// the active-low seven-segment font and the CSoC reset-release delay.
package csoc_tester_pkg;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_IDLE = 3'd4
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    localparam int unsigned RST_RELEASE_CYCLES = 16;

    // Segments g..a, active-low; entry 15 is listed first
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [7:0] hex_to_sseg(input logic [3:0] nib);
        return {1'b1, HEX_SEG[nib]};
    endfunction

endpackage

// File: rtl/csoc_tester_if.sv
// Parallel byte link between the CSoC and the tester; the tester is the slave.
interface csoc_tester_if;
    logic       csoc_uart_write;
    logic       csoc_uart_read;
    logic [7:0] csoc_data_i;
    logic [7:0] csoc_data_o;

    modport master (
        output csoc_uart_write,
        output csoc_data_i,
        input  csoc_uart_read,
        input  csoc_data_o
    );

    modport slave (
        input  csoc_uart_write,
        input  csoc_data_i,
        output csoc_uart_read,
        output csoc_data_o
    );
endinterface

// File: rtl/csoc_tester_uart_rx.sv
// 8N1 UART receiver with a 2-FF input synchronizer; a framing error parks the
// receiver until the line returns high so a stuck-low line yields no bytes.
module uart_rx_8n1
    import csoc_tester_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       valid_o
);
    localparam int unsigned CNT_W = $clog2(BAUD_DIV + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);

    rx_state_e        state_q;
    logic             rx_meta_q;
    logic             rx_sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic [7:0]       byte_q;
    logic             valid_q;

    assign byte_o  = byte_q;
    assign valid_o = valid_q;

    // Synchronizer and receive state machine
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RX_IDLE;
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            cnt_q     <= '0;
            bit_q     <= 3'd0;
            shift_q   <= 8'h00;
            byte_q    <= 8'h00;
            valid_q   <= 1'b0;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            valid_q   <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    cnt_q <= '0;
                    if (!rx_sync_q) begin
                        state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q   <= '0;
                        bit_q   <= 3'd0;
                        state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_sync_q, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_q <= RX_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q <= '0;
                        if (rx_sync_q) begin
                            byte_q  <= shift_q;
                            valid_q <= 1'b1;
                            state_q <= RX_IDLE;
                        end else begin
                            state_q <= RX_WAIT_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RX_WAIT_IDLE: begin
                    cnt_q <= '0;
                    if (rx_sync_q) begin
                        state_q <= RX_IDLE;
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/csoc_tester_uart_tx.sv
// 8N1 UART transmitter started by a rising edge of a synchronized write
// request; requests arriving while a frame is in flight are ignored.
module uart_tx_8n1
    import csoc_tester_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_i,
    input  logic [7:0] data_i,
    output logic       tx_o,
    output logic [7:0] byte_o
);
    localparam int unsigned CNT_W = $clog2(BAUD_DIV + 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BAUD_DIV - 1);

    tx_state_e        state_q;
    logic             wr_meta_q;
    logic             wr_sync_q;
    logic             wr_prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic [7:0]       byte_q;
    logic             tx_q;
    logic             req_s;

    assign req_s  = wr_sync_q & ~wr_prev_q;
    assign tx_o   = tx_q;
    assign byte_o = byte_q;

    // Request synchronizer and transmit state machine
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= TX_IDLE;
            wr_meta_q <= 1'b0;
            wr_sync_q <= 1'b0;
            wr_prev_q <= 1'b0;
            cnt_q     <= '0;
            bit_q     <= 3'd0;
            shift_q   <= 8'h00;
            byte_q    <= 8'h00;
            tx_q      <= 1'b1;
        end else begin
            wr_meta_q <= wr_i;
            wr_sync_q <= wr_meta_q;
            wr_prev_q <= wr_sync_q;
            case (state_q)
                TX_IDLE: begin
                    cnt_q <= '0;
                    tx_q  <= 1'b1;
                    if (req_s) begin
                        shift_q <= data_i;
                        byte_q  <= data_i;
                        tx_q    <= 1'b0;
                        state_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        bit_q   <= 3'd0;
                        tx_q    <= shift_q[0];
                        state_q <= TX_DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                TX_DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q <= '0;
                        if (bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= TX_STOP;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= {1'b0, shift_q[7:1]};
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                TX_STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= TX_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/csoc_tester.sv
// FPGA-side CSoC test harness: clock/reset generation for the CSoC, a UART
// bridge to its byte interface, and LED / seven-segment traffic display.
module csoc_tester
    import csoc_tester_pkg::*;
#(
    parameter int unsigned CLK_FREQ      = 50000000,
    parameter int unsigned BAUD          = 115200,
    parameter int unsigned CSOC_DIV_LOG2 = 2,
    parameter int unsigned REFRESH_LOG2  = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx,
    output logic          tx,
    output logic [7:0]    leds,
    output logic [7:0]    sseg,
    output logic [3:0]    an,
    output logic          csoc_clk,
    output logic          csoc_rstn,
    output logic          csoc_test_se,
    output logic          csoc_test_tm,
    csoc_tester_if.slave  csoc_bus
);
    localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD;
    localparam int unsigned RST_W    = $clog2(RST_RELEASE_CYCLES + 1);

    logic [CSOC_DIV_LOG2-1:0] csoc_div_q;
    logic [RST_W-1:0]         rst_cnt_q;
    logic                     csoc_rstn_q;
    logic [CSOC_DIV_LOG2-1:0] strobe_cnt_q;
    logic                     read_q;
    logic [7:0]               rx_byte_q;
    logic [REFRESH_LOG2-1:0]  refresh_q;
    logic [1:0]               digit_q;
    logic [1:0]               digit_d;
    logic [3:0]               nibble_s;
    logic [3:0]               an_q;
    logic [7:0]               sseg_q;
    logic [7:0]               rx_data_s;
    logic                     rx_valid_s;
    logic [7:0]               tx_byte_s;

    assign csoc_clk             = csoc_div_q[CSOC_DIV_LOG2-1];
    assign csoc_rstn            = csoc_rstn_q;
    assign csoc_test_se         = 1'b0;
    assign csoc_test_tm         = 1'b0;
    assign csoc_bus.csoc_uart_read = read_q;
    assign csoc_bus.csoc_data_o    = rx_byte_q;
    assign leds                 = rx_byte_q;
    assign an                   = an_q;
    assign sseg                 = sseg_q;

    uart_rx_8n1 #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk     (clk),
        .rst     (rst),
        .rx_i    (rx),
        .byte_o  (rx_data_s),
        .valid_o (rx_valid_s)
    );

    uart_tx_8n1 #(.BAUD_DIV(BAUD_DIV)) u_tx (
        .clk    (clk),
        .rst    (rst),
        .wr_i   (csoc_bus.csoc_uart_write),
        .data_i (csoc_bus.csoc_data_i),
        .tx_o   (tx),
        .byte_o (tx_byte_s)
    );

    // CSoC clock divider and delayed reset release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csoc_div_q  <= '0;
            rst_cnt_q   <= '0;
            csoc_rstn_q <= 1'b0;
        end else begin
            csoc_div_q <= csoc_div_q + CSOC_DIV_LOG2'(1);
            if (rst_cnt_q != RST_W'(RST_RELEASE_CYCLES)) begin
                rst_cnt_q <= rst_cnt_q + RST_W'(1);
            end
            csoc_rstn_q <= (rst_cnt_q >= RST_W'(RST_RELEASE_CYCLES - 1));
        end
    end

    // Latch host bytes and stretch the read strobe over one csoc_clk period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_byte_q    <= 8'h00;
            strobe_cnt_q <= '0;
            read_q       <= 1'b0;
        end else if (rx_valid_s) begin
            rx_byte_q    <= rx_data_s;
            strobe_cnt_q <= '1;
            read_q       <= 1'b1;
        end else if (strobe_cnt_q != '0) begin
            strobe_cnt_q <= strobe_cnt_q - CSOC_DIV_LOG2'(1);
            read_q       <= 1'b1;
        end else begin
            read_q <= 1'b0;
        end
    end

    // Next digit index and the nibble it displays
    always_comb begin
        digit_d  = digit_q;
        nibble_s = 4'h0;
        if (&refresh_q) begin
            digit_d = digit_q + 2'd1;
        end else begin
            digit_d = digit_q;
        end
        case (digit_d)
            2'd3:    nibble_s = rx_byte_q[7:4];
            2'd2:    nibble_s = rx_byte_q[3:0];
            2'd1:    nibble_s = tx_byte_s[7:4];
            default: nibble_s = tx_byte_s[3:0];
        endcase
    end

    // Display refresh: anode and segments registered together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_q <= '0;
            digit_q   <= 2'd0;
            an_q      <= 4'b1110;
            sseg_q    <= hex_to_sseg(4'h0);
        end else begin
            refresh_q <= refresh_q + REFRESH_LOG2'(1);
            digit_q   <= digit_d;
            an_q      <= ~(4'b0001 << digit_d);
            sseg_q    <= hex_to_sseg(nibble_s);
        end
    end

endmodule

// File: tb/tb_csoc_tester.sv
// Self-checking bench for csoc_tester: UART framing both ways, strobe width,
// display contents, busy/boundary request drops, stuck line and reset abort.
module tb_csoc_tester;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       tx;
    logic [7:0] leds;
    logic [7:0] sseg;
    logic [3:0] an;
    logic       csoc_clk, csoc_rstn, csoc_test_se, csoc_test_tm;

    csoc_tester_if bus ();

    csoc_tester #(
        .CLK_FREQ(1600), .BAUD(100), .CSOC_DIV_LOG2(2), .REFRESH_LOG2(2)
    ) dut (
        .clk(clk), .rst(rst), .rx(rx), .tx(tx), .leds(leds), .sseg(sseg), .an(an),
        .csoc_clk(csoc_clk), .csoc_rstn(csoc_rstn),
        .csoc_test_se(csoc_test_se), .csoc_test_tm(csoc_test_tm),
        .csoc_bus(bus.slave)
    );

    always #5 clk = ~clk;

    localparam int BIT_CLKS = 16;
    // Standard hex font, segments g..a active-high
    localparam logic [6:0] FONT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_byte;
        int         exp_hi;
    } rx_vec_t;

    int n_checks = 0;
    int n_pass   = 0;
    int read_hi = 0;
    int read_pulses = 0;
    logic read_prev = 1'b0;
    logic [7:0] model_rx = 8'h00;

    always @(negedge clk) begin
        if (bus.csoc_uart_read === 1'b1) begin
            read_hi++;
            if (read_prev !== 1'b1) read_pulses++;
        end
        read_prev = bus.csoc_uart_read;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rx = stop;
        repeat (BIT_CLKS) @(negedge clk);
        rx = 1'b1;
        repeat (24) @(negedge clk);
    endtask

    // Requests a frame of d and checks every clock of its 10 bits; optionally
    // raises a second request at sample index inj_at of that frame.
    task automatic tx_frame(input logic [7:0] d, input int inj_at, input logic [7:0] inj_d);
        logic [9:0]   exp_bits;
        logic [159:0] smp;
        int waited;
        int hits;
        exp_bits = {1'b1, d, 1'b0};
        @(negedge clk);
        bus.csoc_data_i     = d;
        bus.csoc_uart_write = 1'b1;
        waited = 0;
        while (tx !== 1'b0 && waited < 40) begin
            tick();
            waited++;
        end
        bus.csoc_uart_write = 1'b0;
        chk("tx start within bound", tx, 1'b0);
        for (int k = 0; k < 160; k++) begin
            smp[k] = tx;
            if (k == inj_at) begin
                bus.csoc_data_i     = inj_d;
                bus.csoc_uart_write = 1'b1;
            end
            if (k == inj_at + 4) bus.csoc_uart_write = 1'b0;
            if (k < 159) tick();
        end
        for (int b = 0; b < 10; b++) begin
            hits = 0;
            for (int s = 0; s < BIT_CLKS; s++)
                if (smp[b*BIT_CLKS + s] === exp_bits[b]) hits++;
            chk($sformatf("tx byte %02h bit %0d clocks", d, b), hits, BIT_CLKS);
        end
    endtask

    task automatic check_digit(input int d, input logic [3:0] nib);
        logic [3:0] exp_an;
        int waited;
        exp_an = ~(4'b0001 << d);
        waited = 0;
        while (an !== exp_an && waited < 20) begin
            tick();
            waited++;
        end
        chk($sformatf("anode digit %0d", d), an, exp_an);
        chk($sformatf("sseg digit %0d", d), sseg, {1'b1, ~FONT[nib]});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rx_vec_t    vecs [5];
        logic [7:0] b;
        logic [7:0] last_tx;
        logic       st;
        int         zeros;
        int         waited;

        bus.csoc_uart_write = 1'b0;
        bus.csoc_data_i     = 8'h00;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("reset tx", tx, 1'b1);
        chk("reset leds", leds, 8'h00);
        chk("reset data_o", bus.csoc_data_o, 8'h00);
        chk("reset read", bus.csoc_uart_read, 1'b0);
        chk("reset csoc_clk", csoc_clk, 1'b0);
        chk("reset csoc_rstn", csoc_rstn, 1'b0);
        chk("reset an", an, 4'b1110);
        chk("reset sseg", sseg, {1'b1, ~FONT[0]});
        chk("test_se", csoc_test_se, 1'b0);
        chk("test_tm", csoc_test_tm, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk($sformatf("csoc_clk after %0d", k), csoc_clk, ((k % 4) >= 2));
            chk($sformatf("csoc_rstn after %0d", k), csoc_rstn, (k >= 16));
        end

        // Host to CSoC vectors
        vecs[0] = '{8'h00, 1'b1, 8'h00, 4};
        vecs[1] = '{8'hFF, 1'b1, 8'hFF, 4};
        vecs[2] = '{8'h3C, 1'b0, 8'hFF, 0};
        vecs[3] = '{8'h81, 1'b1, 8'h81, 4};
        vecs[4] = '{8'hA5, 1'b1, 8'hA5, 4};
        foreach (vecs[i]) begin
            read_hi = 0;
            send_rx(vecs[i].data, vecs[i].stop);
            chk($sformatf("vec %0d data_o", i), bus.csoc_data_o, vecs[i].exp_byte);
            chk($sformatf("vec %0d leds", i), leds, vecs[i].exp_byte);
            chk($sformatf("vec %0d read cycles", i), read_hi, vecs[i].exp_hi);
        end
        model_rx = 8'hA5;
        check_digit(3, 4'hA);
        check_digit(2, 4'h5);

        // CSoC to host with a dropped mid-frame request
        tx_frame(8'h3C, 50, 8'h55);
        zeros = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (tx !== 1'b1) zeros++;
        end
        chk("busy request dropped", zeros, 0);
        check_digit(1, 4'h3);
        check_digit(0, 4'hC);

        // Request landing on the final stop-bit clock is dropped
        tx_frame(8'h69, 157, 8'h12);
        zeros = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (k == 3) bus.csoc_uart_write = 1'b0;
            if (tx !== 1'b1) zeros++;
        end
        chk("stop-end request dropped", zeros, 0);

        // One clock later it is accepted
        tx_frame(8'h69, 158, 8'h96);
        tick();
        chk("stop bit still high", tx, 1'b1);
        tick();
        chk("next frame starts", tx, 1'b0);
        bus.csoc_uart_write = 1'b0;
        repeat (200) tick();
        check_digit(1, 4'h9);
        check_digit(0, 4'h6);

        // Stuck-low line
        read_hi = 0;
        read_pulses = 0;
        @(negedge clk);
        rx = 1'b0;
        repeat (1000) @(negedge clk);
        chk("stuck line pulses", read_pulses, 0);
        chk("stuck line data_o", bus.csoc_data_o, model_rx);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        send_rx(8'h01, 1'b1);
        model_rx = 8'h01;
        chk("after stuck data_o", bus.csoc_data_o, model_rx);

        // Random host bytes, some with a bad stop bit
        for (int i = 0; i < 8; i++) begin
            b  = 8'($urandom);
            st = ($urandom_range(3) != 0);
            read_hi = 0;
            send_rx(b, st);
            if (st) model_rx = b;
            chk($sformatf("rand rx %0d data_o", i), bus.csoc_data_o, model_rx);
            chk($sformatf("rand rx %0d read cycles", i), read_hi, st ? 4 : 0);
        end
        check_digit(3, model_rx[7:4]);
        check_digit(2, model_rx[3:0]);

        // Random CSoC bytes
        last_tx = 8'h00;
        for (int i = 0; i < 3; i++) begin
            last_tx = 8'($urandom);
            tx_frame(last_tx, -1, 8'h00);
            repeat (8) tick();
        end
        check_digit(1, last_tx[7:4]);
        check_digit(0, last_tx[3:0]);

        // Reset in the middle of a transmit frame
        @(negedge clk);
        bus.csoc_data_i     = 8'hC3;
        bus.csoc_uart_write = 1'b1;
        waited = 0;
        while (tx !== 1'b0 && waited < 40) begin
            tick();
            waited++;
        end
        bus.csoc_uart_write = 1'b0;
        repeat (88) tick();
        chk("tx low before reset", tx, 1'b0);
        rst = 1'b1;
        #1;
        chk("tx high on reset", tx, 1'b1);
        chk("csoc_rstn low on reset", csoc_rstn, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (30) tick();
        chk("tx idle after reset", tx, 1'b1);
        tx_frame(8'($urandom), -1, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/csoc_tester.md
Name: csoc_tester

Overview:
- FPGA-side test harness for the CSoC chip.
- Generates the CSoC clock, reset and scan-control pins, and bridges a host UART (rx/tx) to the CSoC's 8-bit parallel byte interface.
- Shows traffic on 8 LEDs and a 4-digit multiplexed seven-segment display.
- Sits at the FPGA top level between board pins and the CSoC socket.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, UART bit rate. Bit period BAUD_DIV = CLK_FREQ/BAUD clocks, integer-truncated.
- CSOC_DIV_LOG2, 2, csoc_clk = clk / 2^CSOC_DIV_LOG2. Minimum 1.
- REFRESH_LOG2, 16, seven-segment digit switch every 2^REFRESH_LOG2 clocks.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- rx  in  1  UART receive from host, idle high.
- tx  out  1  UART transmit to host, idle high.
- leds  out  8  last byte received from host.
- sseg  out  8  segments, active-low, bit7=dp, bits6:0 = g..a.
- an  out  4  digit anodes, active-low, one-hot.
- csoc_clk  out  1  divided clock to CSoC.
- csoc_rstn  out  1  active-low CSoC reset.
- csoc_test_se  out  1  scan enable, tied 0.
- csoc_test_tm  out  1  test mode, tied 0.
- csoc_uart_write  in  1  CSoC request: transmit csoc_data_i.
- csoc_uart_read  out  1  CSoC strobe: csoc_data_o holds a new host byte.
- csoc_data_i  in  8  byte from CSoC to transmit.
- csoc_data_o  out  8  byte received from host.

Behaviour:
- Reset: one clock domain (clk); reset is asynchronous and active-high on rst.
- Reset values:
  - tx=1, leds=0, csoc_data_o=0, csoc_uart_read=0, csoc_clk=0, csoc_rstn=0.
  - an=4'b1110; sseg shows digit '0' with dp off.
  - All counters 0.
- csoc_clk: free-running toggle from a CSOC_DIV_LOG2-bit counter (MSB), 50% duty.
- csoc_rstn: released 16 clk cycles after rst deasserts, via a synchronous counter. Reasserted asynchronously by rst.
- UART RX:
  - 8N1, LSB first, inputs through a 2-FF synchronizer.
  - States IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE→START on synchronized rx=0. START re-samples at BAUD_DIV/2: if 1, glitch → IDLE.
  - DATA samples 8 bits every BAUD_DIV.
  - STOP sample=1: byte valid. Latch csoc_data_o and leds; csoc_uart_read=1 for 2^CSOC_DIV_LOG2 clk cycles, so it covers one full csoc_clk period.
  - STOP sample=0: framing error. Discard the byte, go to WAIT_IDLE, and stay there until rx=1. A constant-0 line therefore produces no bytes and no csoc_uart_read strobes.
- UART TX:
  - csoc_uart_write passes through a 2-FF synchronizer; its rising edge is one write request.
  - In TX IDLE the request captures csoc_data_i into a shift register, then sends start, 8 data bits LSB first, stop, each BAUD_DIV clocks.
  - A request while busy is dropped; no queue.
  - A request in the same cycle the stop bit ends is dropped; a request one cycle later is accepted.
- Display:
  - Digits 3..0 = rx byte high/low nibble, then tx byte high/low nibble, in hex.
  - Tx byte = last accepted csoc_data_i.
  - Digit index advances every 2^REFRESH_LOG2 clocks and wraps 3→0.
  - Hex font standard: 0..9, A, b, C, d, E, F.
- Reset mid-frame: both FSMs abort immediately to IDLE, tx=1.

Decomposition:
- Package csoc_tester_pkg: UART state enums, the 16-entry hex-to-segment constant table, reset-release count 16.
- Natural sub-modules: uart_rx_8n1 and uart_tx_8n1, each parameterized by BAUD_DIV.
- The display mux and clock/reset generation stay inline.

Test Plan:
Bench parameters: CLK_FREQ=1600, BAUD=100 (BAUD_DIV=16), CSOC_DIV_LOG2=2, REFRESH_LOG2=2.
1. Reset:
   - Stimulus: hold rst 3 cycles, release.
   - Response: tx=1, csoc_rstn=0 for 16 cycles then 1, csoc_clk toggles every 2 clk, csoc_test_se=csoc_test_tm=0.
2. Host→CSoC:
   - Stimulus: send 0xA5 on rx, 8N1.
   - Response: csoc_data_o=0xA5, leds=0xA5, csoc_uart_read high exactly 4 clk. Digits 3/2 show "A","5".
3. CSoC→host:
   - Stimulus: csoc_data_i=0x3C, pulse csoc_uart_write.
   - Response: tx frame 0,0,0,1,1,1,1,0,0,1 (start, LSB-first data, stop), 16 clk per bit. Digits 1/0 show "3","C".
4. Busy drop:
   - Stimulus: second write of 0x55 mid-frame.
   - Response: only the 0x3C frame appears; the tx digits stay "3C".
5. Framing/stuck line:
   - Stimulus: rx held 0 for 1000 clk.
   - Response: zero csoc_uart_read pulses, csoc_data_o unchanged. After rx=1 then 0x01 is sent, csoc_data_o=0x01.
6. Reset mid-frame:
   - Stimulus: assert rst during TX bit 4.
   - Response: tx=1 immediately; the next write transmits a full clean frame.
